// File: rtl/fill_arb_pkg.sv
// Shared types and defaults for the building fill-valve arbiter.
// State and clock-rate encodings plus timing constants.
package fill_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int FREQ_W = 2;

  typedef enum logic [FREQ_W-1:0] {
    FREQ_1X = 2'b00,
    FREQ_2X = 2'b01,
    FREQ_4X = 2'b10,
    FREQ_8X = 2'b11
  } freq_e;

  localparam int unsigned MAX_FREQ_SHIFT    = 3;
  localparam int unsigned DEF_NUM_MACHINES  = 4;
  localparam int unsigned DEF_TICKS_PER_SEC = 1_000_000;
  localparam int unsigned DEF_FILL_SECONDS  = 120;

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler scaled by clk_freq, with count enable and clear.
// A count at or past the terminal value yields a tick and wraps.
module sec_tick_gen
  import fill_arb_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC_BASE = DEF_TICKS_PER_SEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [FREQ_W-1:0] clk_freq,
  output logic              tick
);

  localparam int unsigned CW =
    $clog2(TICKS_PER_SEC_BASE << MAX_FREQ_SHIFT) + 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] term;

  // >= rather than == so a rate drop mid-second still ticks once
  always_comb begin
    term  = (CW'(TICKS_PER_SEC_BASE) << clk_freq) - CW'(1);
    tick  = en && (cnt_q >= term);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fill_valve_arbiter.sv
// Round-robin owner of the shared water inlet valve.
// Times each fill in seconds; supports pause and owner abort.
module fill_valve_arbiter
  import fill_arb_pkg::*;
#(
  parameter int unsigned NUM_MACHINES       = DEF_NUM_MACHINES,
  parameter int unsigned TICKS_PER_SEC_BASE = DEF_TICKS_PER_SEC,
  parameter int unsigned FILL_SECONDS       = DEF_FILL_SECONDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FREQ_W-1:0]       clk_freq,
  input  logic [NUM_MACHINES-1:0] fill_req,
  input  logic                    valve_pause,
  output logic [NUM_MACHINES-1:0] grant,
  output logic                    valve_open,
  output logic [NUM_MACHINES-1:0] fill_done,
  output logic                    busy
);

  localparam int unsigned IW = idx_w(NUM_MACHINES);
  localparam int unsigned SW = $clog2(FILL_SECONDS + 1);

  state_e state_q;
  state_e state_d;

  logic [IW-1:0] owner_q;
  logic [IW-1:0] owner_d;
  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic [SW-1:0] sec_q;
  logic [SW-1:0] sec_d;

  logic [NUM_MACHINES-1:0] grant_q;
  logic [NUM_MACHINES-1:0] grant_d;
  logic [NUM_MACHINES-1:0] done_q;
  logic [NUM_MACHINES-1:0] done_d;
  logic                    valve_q;
  logic                    valve_d;
  logic                    busy_q;
  logic                    busy_d;

  logic          tick;
  logic          pre_en;
  logic          pre_clr;
  logic          owner_req;
  logic          abort;
  logic          last_sec;
  logic          fill_active;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;

  assign owner_req = fill_req[owner_q];
  assign abort     = ((state_q == ST_FILL) ||
                      (state_q == ST_PAUSED)) && !owner_req;
  assign last_sec  = (sec_q == SW'(FILL_SECONDS - 1));
  assign pre_en    = (state_q == ST_FILL);
  assign pre_clr   = abort ||
                     (state_q == ST_IDLE) ||
                     (state_q == ST_DONE);

  sec_tick_gen #(
    .TICKS_PER_SEC_BASE(TICKS_PER_SEC_BASE)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (pre_en),
    .clr     (pre_clr),
    .clk_freq(clk_freq),
    .tick    (tick)
  );

  // search begins one past the previous owner
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int i = 1; i <= int'(NUM_MACHINES); i++) begin
      cand = IW'((int'(last_q) + i) % int'(NUM_MACHINES));
      if (!win_found && fill_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    sec_d   = sec_q;
    unique case (state_q)
      ST_IDLE: begin
        sec_d = '0;
        if (win_found) begin
          state_d = ST_FILL;
          owner_d = win_idx;
          last_d  = win_idx;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
          sec_d   = '0;
        end else if (tick && last_sec) begin
          state_d = ST_DONE;
          sec_d   = '0;
        end else begin
          if (tick) begin
            sec_d = sec_q + SW'(1);
          end
          if (valve_pause) begin
            state_d = ST_PAUSED;
          end
        end
      end
      ST_PAUSED: begin
        if (abort) begin
          state_d = ST_IDLE;
          sec_d   = '0;
        end else if (!valve_pause) begin
          state_d = ST_FILL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // outputs are decoded from the next state so they register with it
  always_comb begin
    fill_active = (state_d == ST_FILL) ||
                  (state_d == ST_PAUSED);
    grant_d = '0;
    done_d  = '0;
    if (fill_active) begin
      grant_d = NUM_MACHINES'(1) << owner_d;
    end
    if (state_d == ST_DONE) begin
      done_d = NUM_MACHINES'(1) << owner_q;
    end
    valve_d = (state_d == ST_FILL);
    busy_d  = fill_active;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_MACHINES - 1);
      sec_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      valve_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      sec_q   <= sec_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      valve_q <= valve_d;
      busy_q  <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign fill_done  = done_q;
  assign valve_open = valve_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fill_valve_arbiter.sv
// Directed bench for fill_valve_arbiter: vector table
// plus multi-cycle fill, pause, abort and reset sequences.
module tb_fill_valve_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] clk_freq;
  logic [3:0] fill_req;
  logic       valve_pause;
  logic [3:0] grant;
  logic       valve_open;
  logic [3:0] fill_done;
  logic       busy;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fill_valve_arbiter #(
    .NUM_MACHINES      (4),
    .TICKS_PER_SEC_BASE(10),
    .FILL_SECONDS      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_freq   (clk_freq),
    .fill_req   (fill_req),
    .valve_pause(valve_pause),
    .grant      (grant),
    .valve_open (valve_open),
    .fill_done  (fill_done),
    .busy       (busy)
  );

  typedef struct {
    logic       rst;
    logic [1:0] freq;
    logic [3:0] req;
    logic       pause;
    logic [3:0] grant;
    logic       valve;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  vec_t tbl[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    fill_req    = '0;
    valve_pause = 1'b0;
    clk_freq    = 2'b00;
    step();
    rst = 1'b0;
  endtask

  // Called at the first granted sample (cycle 1 of the fill).
  task automatic run_fill(input int pause_at,
                          input int pause_len,
                          input int drop_at,
                          input int rst_at,
                          input logic [3:0] drop_mask,
                          output int open_n,
                          output int closed_n,
                          output int cyc_n,
                          output logic [3:0] done_m,
                          output bit aborted);
    bit fin;
    fin      = 1'b0;
    open_n   = 0;
    closed_n = 0;
    cyc_n    = 0;
    done_m   = '0;
    aborted  = 1'b0;
    for (int i = 1; i <= 2000 && !fin; i++) begin
      if (valve_open) open_n++;
      if (grant != 0 && !valve_open) closed_n++;
      if (fill_done != 0) begin
        done_m = fill_done;
        cyc_n  = i;
        fin    = 1'b1;
      end else if (grant == 0) begin
        aborted = 1'b1;
        cyc_n   = i;
        fin     = 1'b1;
      end else begin
        valve_pause = (pause_len > 0) && (i >= pause_at) &&
                      (i < pause_at + pause_len);
        if (i == drop_at) fill_req = fill_req & ~drop_mask;
        if (i == rst_at) rst = 1'b1;
        step();
      end
    end
    if (!fin) begin
      nvec++;
      nfail++;
      $display("FAIL run_fill timeout: got no end expected end");
    end
  endtask

  initial begin
    int         open_n;
    int         closed_n;
    int         cyc_n;
    int         gap;
    logic [3:0] done_m;
    logic [3:0] exp_g;
    bit         ab;

    //          rst fq  req     pz  grant   vo  done    bsy
    tbl[0]  = '{1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0};
    tbl[1]  = '{0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0};
    tbl[2]  = '{0, 0, 4'b0100, 0, 4'b0100, 1, 4'b0000, 1};
    tbl[3]  = '{0, 0, 4'b0100, 0, 4'b0100, 1, 4'b0000, 1};
    tbl[4]  = '{0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0};
    tbl[5]  = '{0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0};
    tbl[6]  = '{0, 0, 4'b1010, 0, 4'b1000, 1, 4'b0000, 1};
    tbl[7]  = '{0, 0, 4'b1010, 1, 4'b1000, 0, 4'b0000, 1};
    tbl[8]  = '{0, 0, 4'b1010, 1, 4'b1000, 0, 4'b0000, 1};
    tbl[9]  = '{0, 0, 4'b1010, 0, 4'b1000, 1, 4'b0000, 1};
    tbl[10] = '{0, 0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 0};
    tbl[11] = '{0, 0, 4'b0010, 0, 4'b0010, 1, 4'b0000, 1};
    tbl[12] = '{1, 0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 0};
    tbl[13] = '{0, 0, 4'b1111, 0, 4'b0001, 1, 4'b0000, 1};
    tbl[14] = '{0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0};

    rst         = 1'b0;
    clk_freq    = 2'b00;
    fill_req    = '0;
    valve_pause = 1'b0;
    #2;

    for (int k = 0; k < 15; k++) begin
      rst         = tbl[k].rst;
      clk_freq    = tbl[k].freq;
      fill_req    = tbl[k].req;
      valve_pause = tbl[k].pause;
      step();
      chk($sformatf("vec%0d", k),
          {grant, valve_open, fill_done, busy},
          {tbl[k].grant, tbl[k].valve, tbl[k].done, tbl[k].busy});
    end

    // single fill, 30 open cycles
    do_reset();
    fill_req = 4'b0100;
    step();
    chk("s1 grant", grant, 4'b0100);
    run_fill(0, 0, 0, 0, 4'b0, open_n, closed_n, cyc_n, done_m, ab);
    chk("s1 open", open_n, 30);
    chk("s1 done", done_m, 4'b0100);
    chk("s1 grant at done", grant, 4'b0000);
    fill_req = '0;
    step();
    chk("s1 done pulse", fill_done, 4'b0000);

    // all machines request: round robin with 2-cycle gaps
    do_reset();
    fill_req = 4'b1111;
    step();
    for (int m = 0; m < 4; m++) begin
      gap = 0;
      while (grant == 0 && gap < 20) begin
        gap++;
        step();
      end
      exp_g = 4'b0001 << m;
      if (m > 0) chk($sformatf("s2 gap%0d", m), gap, 2);
      chk($sformatf("s2 grant%0d", m), grant, exp_g);
      run_fill(0, 0, 0, 0, 4'b0, open_n, closed_n, cyc_n,
               done_m, ab);
      chk($sformatf("s2 open%0d", m), open_n, 30);
      chk($sformatf("s2 done%0d", m), done_m, exp_g);
    end
    fill_req = '0;

    // 10-cycle pause mid-fill
    do_reset();
    fill_req = 4'b0001;
    step();
    run_fill(10, 10, 0, 0, 4'b0, open_n, closed_n, cyc_n, done_m, ab);
    chk("s3 open", open_n, 30);
    chk("s3 closed", closed_n, 10);
    chk("s3 done cycle", cyc_n, 41);
    chk("s3 done", done_m, 4'b0001);
    valve_pause = 1'b0;

    // pause coincides with final tick: completion wins
    do_reset();
    fill_req = 4'b0001;
    step();
    run_fill(30, 5, 0, 0, 4'b0, open_n, closed_n, cyc_n, done_m, ab);
    chk("s3b done cycle", cyc_n, 31);
    chk("s3b closed", closed_n, 0);
    chk("s3b done", done_m, 4'b0001);
    valve_pause = 1'b0;

    // owner drop at open cycle 15 with machine 2 pending
    do_reset();
    fill_req = 4'b0110;
    step();
    chk("s4 grant", grant, 4'b0010);
    run_fill(0, 0, 15, 0, 4'b0010, open_n, closed_n, cyc_n,
             done_m, ab);
    chk("s4 aborted", ab, 1);
    chk("s4 open", open_n, 15);
    chk("s4 no done", {done_m, fill_done}, 8'h00);
    step();
    chk("s4 next grant", grant, 4'b0100);
    run_fill(0, 0, 0, 0, 4'b0, open_n, closed_n, cyc_n, done_m, ab);
    chk("s4 open2", open_n, 30);
    chk("s4 done2", done_m, 4'b0100);
    fill_req = '0;

    // owner drop coincides with final tick: abort wins
    do_reset();
    fill_req = 4'b0001;
    step();
    run_fill(0, 0, 30, 0, 4'b0001, open_n, closed_n, cyc_n,
             done_m, ab);
    chk("s4b aborted", ab, 1);
    chk("s4b open", open_n, 30);
    chk("s4b no done", done_m, 4'b0000);
    step();
    chk("s4b idle", {grant, fill_done}, 8'h00);

    // 8x clock rate
    do_reset();
    clk_freq = 2'b11;
    fill_req = 4'b1000;
    step();
    chk("s5 grant", grant, 4'b1000);
    run_fill(0, 0, 0, 0, 4'b0, open_n, closed_n, cyc_n, done_m, ab);
    chk("s5 open", open_n, 240);
    chk("s5 done", done_m, 4'b1000);
    fill_req = '0;
    clk_freq = 2'b00;

    // reset mid-fill
    do_reset();
    fill_req = 4'b0100;
    step();
    run_fill(0, 0, 0, 20, 4'b0, open_n, closed_n, cyc_n, done_m, ab);
    chk("s6 outputs", {grant, valve_open, fill_done, busy}, 10'h000);
    chk("s6 open", open_n, 20);
    chk("s6 no done", done_m, 4'b0000);
    rst      = 1'b0;
    fill_req = 4'b1111;
    step();
    chk("s6 grant after rst", grant, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
